// File: rtl/set_assoc_cache.sv
// Set-associative write-back cache array with true-LRU replacement; one word per line.
// Response registered one cycle after acceptance; no backpressure, a request is taken every valid cycle.
module set_assoc_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SETS   = 8,
    parameter int NUM_WAYS   = 4
) (
    input  logic                  clk_i,
    input  logic                  aresetn_i,
    input  logic                  req_valid_i,
    input  logic                  write_enable_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  hit_o,
    output logic                  miss_o,
    output logic                  evict_valid_o,
    output logic [ADDR_WIDTH-1:0] evict_addr_o,
    output logic [DATA_WIDTH-1:0] evict_data_o
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;

    logic                  valid_q [NUM_SETS][NUM_WAYS];
    logic                  dirty_q [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]      age_q   [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] victim_way;
    logic [WAY_W-1:0] acc_way;
    logic [WAY_W-1:0] old_age;
    logic             do_alloc;
    logic             do_touch;
    logic             do_evict;

    assign idx = addr_i[IDX_W-1:0];
    assign tag = addr_i[ADDR_WIDTH-1:IDX_W];

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            // Lowest-numbered invalid way wins, so only the first one found is kept.
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_q[idx][w] == WAY_W'(NUM_WAYS - 1)) begin
                lru_way = WAY_W'(w);
            end
        end
        victim_way = inv_found ? inv_way : lru_way;
        acc_way    = hit ? hit_way : victim_way;
        old_age    = age_q[idx][acc_way];
        do_alloc   = req_valid_i && write_enable_i && !hit;
        do_touch   = req_valid_i && (hit || write_enable_i);
        do_evict   = do_alloc && valid_q[idx][victim_way] && dirty_q[idx][victim_way];
    end

    // Control state: valid, dirty and LRU ages are the only arrays that need reset.
    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else if (do_touch) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == acc_way) begin
                    age_q[idx][w] <= '0;
                end else if (age_q[idx][w] < old_age) begin
                    age_q[idx][w] <= age_q[idx][w] + WAY_W'(1);
                end
            end
            if (write_enable_i) begin
                valid_q[idx][acc_way] <= 1'b1;
                dirty_q[idx][acc_way] <= 1'b1;
            end
        end
    end

    // Payload arrays carry no reset; reset only blocks the write.
    always_ff @(posedge clk_i) begin
        if (aresetn_i && req_valid_i && write_enable_i) begin
            data_q[idx][acc_way] <= data_i;
            if (!hit) begin
                tag_q[idx][acc_way] <= tag;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            resp_valid_o  <= 1'b0;
            hit_o         <= 1'b0;
            miss_o        <= 1'b0;
            data_o        <= '0;
            evict_valid_o <= 1'b0;
            evict_addr_o  <= '0;
            evict_data_o  <= '0;
        end else begin
            resp_valid_o  <= req_valid_i;
            hit_o         <= req_valid_i && hit;
            miss_o        <= req_valid_i && !hit;
            data_o        <= (req_valid_i && !write_enable_i && hit) ? data_q[idx][hit_way] : '0;
            evict_valid_o <= do_evict;
            evict_addr_o  <= do_evict ? {tag_q[idx][victim_way], idx} : '0;
            evict_data_o  <= do_evict ? data_q[idx][victim_way] : '0;
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed scoreboard bench for set_assoc_cache at default parameters (index = addr[2:0]).
module tb_set_assoc_cache;

    logic        clk_i = 1'b0;
    logic        aresetn_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        write_enable_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic        resp_valid_o;
    logic [31:0] data_o;
    logic        hit_o;
    logic        miss_o;
    logic        evict_valid_o;
    logic [31:0] evict_addr_o;
    logic [31:0] evict_data_o;

    set_assoc_cache dut (
        .clk_i          (clk_i),
        .aresetn_i      (aresetn_i),
        .req_valid_i    (req_valid_i),
        .write_enable_i (write_enable_i),
        .addr_i         (addr_i),
        .data_i         (data_i),
        .resp_valid_o   (resp_valid_o),
        .data_o         (data_o),
        .hit_o          (hit_o),
        .miss_o         (miss_o),
        .evict_valid_o  (evict_valid_o),
        .evict_addr_o   (evict_addr_o),
        .evict_data_o   (evict_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          id;
        logic        we;
        logic        hit;
        logic [31:0] data;
        logic        ev;
        logic [31:0] ev_addr;
        logic [31:0] ev_data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;

    localparam logic [31:0] D08 = 32'h1111_0008;
    localparam logic [31:0] D10 = 32'h2222_0010;
    localparam logic [31:0] D18 = 32'h3333_0018;
    localparam logic [31:0] D20 = 32'h4444_0020;
    localparam logic [31:0] D28 = 32'h5555_0028;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (req #%0d): got 0x%08h, expected 0x%08h", name, id, act, req);
        end
    endtask

    // Drive one request on the falling edge and queue its expected response.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_hit, input logic [31:0] exp_data,
                         input logic exp_ev, input logic [31:0] exp_ev_addr, input logic [31:0] exp_ev_data);
        exp_t e;
        @(negedge clk_i);
        req_valid_i    = 1'b1;
        write_enable_i = we;
        addr_i         = addr;
        data_i         = wdata;
        e.id      = next_id;
        e.we      = we;
        e.hit     = exp_hit;
        e.data    = exp_data;
        e.ev      = exp_ev;
        e.ev_addr = exp_ev_addr;
        e.ev_data = exp_ev_data;
        exp_q.push_back(e);
        next_id++;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic exp_hit,
                      input logic exp_ev, input logic [31:0] exp_ev_addr, input logic [31:0] exp_ev_data);
        issue(1'b1, addr, wdata, exp_hit, 32'h0, exp_ev, exp_ev_addr, exp_ev_data);
    endtask

    task automatic rd(input logic [31:0] addr, input logic exp_hit, input logic [31:0] exp_data);
        issue(1'b0, addr, 32'h0, exp_hit, exp_data, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic idle(input int n);
        @(negedge clk_i);
        req_valid_i    = 1'b0;
        write_enable_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        aresetn_i   = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        aresetn_i   = 1'b1;
    endtask

    // Monitor: pops one expectation per response; idle cycles must show quiet outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (resp_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got resp_valid=1, expected no response");
                end else begin
                    e = exp_q.pop_front();
                    chk("hit", e.id, {31'b0, hit_o}, {31'b0, e.hit});
                    chk("miss", e.id, {31'b0, miss_o}, {31'b0, !e.hit});
                    if (!e.we) chk("rdata", e.id, data_o, e.data);
                    chk("evict_valid", e.id, {31'b0, evict_valid_o}, {31'b0, e.ev});
                    chk("evict_addr", e.id, evict_addr_o, e.ev_addr);
                    chk("evict_data", e.id, evict_data_o, e.ev_data);
                end
            end else begin
                chk("idle_valid", -1, {31'b0, resp_valid_o}, 32'h0);
                chk("idle_hit_miss", -1, {30'b0, hit_o, miss_o}, 32'h0);
                chk("idle_data", -1, data_o, 32'h0);
                chk("idle_evict", -1, {31'b0, evict_valid_o}, 32'h0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk_i);
        aresetn_i = 1'b1;

        // Cold read miss, then write-allocate and read back.
        rd(32'h10, 1'b0, 32'h0);
        wr(32'h10, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0, 32'h0);
        rd(32'h10, 1'b1, 32'hA5A5_0001);
        idle(2);

        // Fill set 0, fifth write evicts the oldest line (0x08).
        do_reset();
        wr(32'h08, D08, 1'b0, 1'b0, 32'h0, 32'h0);
        wr(32'h10, D10, 1'b0, 1'b0, 32'h0, 32'h0);
        wr(32'h18, D18, 1'b0, 1'b0, 32'h0, 32'h0);
        wr(32'h20, D20, 1'b0, 1'b0, 32'h0, 32'h0);
        wr(32'h28, D28, 1'b0, 1'b1, 32'h08, D08);
        rd(32'h08, 1'b0, 32'h0);
        rd(32'h28, 1'b1, D28);
        idle(2);

        // Touching 0x08 makes 0x10 the LRU victim.
        do_reset();
        wr(32'h08, D08, 1'b0, 1'b0, 32'h0, 32'h0);
        wr(32'h10, D10, 1'b0, 1'b0, 32'h0, 32'h0);
        wr(32'h18, D18, 1'b0, 1'b0, 32'h0, 32'h0);
        wr(32'h20, D20, 1'b0, 1'b0, 32'h0, 32'h0);
        rd(32'h08, 1'b1, D08);
        wr(32'h28, D28, 1'b0, 1'b1, 32'h10, D10);
        rd(32'h08, 1'b1, D08);
        rd(32'h10, 1'b0, 32'h0);
        idle(2);

        // Back-to-back writes to one address, then read.
        do_reset();
        wr(32'h30, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
        wr(32'h30, 32'h2, 1'b1, 1'b0, 32'h0, 32'h0);
        rd(32'h30, 1'b1, 32'h2);

        // Reset with a read pending: no response, array cleared.
        wr(32'h40, 32'hDEAD_0040, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk_i);
        aresetn_i      = 1'b0;
        req_valid_i    = 1'b1;
        write_enable_i = 1'b0;
        addr_i         = 32'h40;
        @(negedge clk_i);
        aresetn_i      = 1'b1;
        req_valid_i    = 1'b0;
        rd(32'h40, 1'b0, 32'h0);
        rd(32'h30, 1'b0, 32'h0);
        idle(4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
